boot_loader: RTL and testbench

Program-image loader that sits directly upstream of the 16-bit pipelined CPU's instruction memory. After reset it accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. It writes each word into instruction memory at consecutive even addresses. Once the image is complete it asserts cpu_run, which releases the CPU core from reset so it fetches from BASE_ADDR.

---
 rtl/boot_loader.sv | 198 +++++++++++++++++++
 tb/tb_boot_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// boot_loader: program-image loader feeding the CPU instruction memory.
//
// Accepts a byte stream over a valid/ready handshake. The first two bytes
// are a big-endian word count. That many big-endian 16-bit words follow.
// Each word is written to instruction memory at BASE_ADDR + 2*index. When
// the image is complete, cpu_run is raised, which releases the CPU core.
//
// Optional feature macro: BOOT_CHECKSUM_EN
//   When defined, a 2-byte checksum (MSB first) follows the image. It must
//   equal the modulo-2^16 sum of all written words, otherwise the load
//   ends in ERR. When undefined, the checksum states and the sum register
//   are not built.
//
// Ports:
//   clock       system clock, rising edge
//   reset       synchronous, active-low reset
//   rx_data     incoming image byte
//   rx_valid    rx_data valid this cycle
//   rx_ready    loader accepts a byte this cycle (registered)
//   imem_we     instruction-memory write strobe, one cycle per word
//   imem_addr   instruction-memory byte address (always even)
//   imem_wdata  instruction word {high byte, low byte}
//   cpu_run     image loaded; CPU released from reset
//   busy        load in progress (not DONE / ERR)
//   error       sticky load failure
//   word_count  words written so far
module boot_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 256,
  parameter int          CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             imem_we,
  output logic [15:0]      imem_addr,
  output logic [15:0]      imem_wdata,
  output logic             cpu_run,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [3:0] {
    LEN_HI,
    LEN_LO,
    DAT_HI,
    DAT_LO,
    WRITE,
    DONE,
`ifdef BOOT_CHECKSUM_EN
    CHK_HI,
    CHK_LO,
`endif
    ERR
  } state_t;

  state_t           state_reg;
  logic [15:0]      len_reg;
  logic [7:0]       hi_reg;
  logic             rx_accept;
  logic [CNT_W-1:0] count_next;
  logic [15:0]      len_full;
`ifdef BOOT_CHECKSUM_EN
  logic [15:0]      sum_reg;
`endif

  assign rx_accept  = rx_valid && rx_ready;
  assign count_next = word_count + CNT_W'(1);
  // Full length as it will be once the low byte is latched in LEN_LO.
  assign len_full   = {len_reg[15:8], rx_data};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg  <= LEN_HI;
      rx_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 16'h0000;
      cpu_run    <= 1'b0;
      busy       <= 1'b1;
      error      <= 1'b0;
      word_count <= '0;
      len_reg    <= 16'h0000;
      hi_reg     <= 8'h00;
`ifdef BOOT_CHECKSUM_EN
      sum_reg    <= 16'h0000;
`endif
    end else begin
      // Outputs are registered: every transition also sets the output
      // values that belong to its destination state.
      case (state_reg)
        LEN_HI: begin
          if (rx_accept) begin
            len_reg[15:8] <= rx_data;
            state_reg     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (rx_accept) begin
            len_reg[7:0] <= rx_data;
            if (len_full == 16'h0000) begin
`ifdef BOOT_CHECKSUM_EN
              state_reg <= CHK_HI;
`else
              state_reg <= DONE;
              rx_ready  <= 1'b0;
              cpu_run   <= 1'b1;
              busy      <= 1'b0;
`endif
            end else if (32'(len_full) > 32'(MAX_WORDS)) begin
              state_reg <= ERR;
              rx_ready  <= 1'b0;
              error     <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state_reg <= DAT_HI;
            end
          end
        end
        DAT_HI: begin
          if (rx_accept) begin
            hi_reg    <= rx_data;
            state_reg <= DAT_LO;
          end
        end
        DAT_LO: begin
          if (rx_accept) begin
            imem_wdata <= {hi_reg, rx_data};
            imem_addr  <= BASE_ADDR + (16'(word_count) << 1);
            imem_we    <= 1'b1;
            rx_ready   <= 1'b0;
            state_reg  <= WRITE;
          end
        end
        WRITE: begin
          imem_we    <= 1'b0;
          word_count <= count_next;
`ifdef BOOT_CHECKSUM_EN
          sum_reg    <= sum_reg + imem_wdata;
`endif
          if (32'(count_next) == 32'(len_reg)) begin
`ifdef BOOT_CHECKSUM_EN
            state_reg <= CHK_HI;
            rx_ready  <= 1'b1;
`else
            state_reg <= DONE;
            cpu_run   <= 1'b1;
            busy      <= 1'b0;
`endif
          end else begin
            state_reg <= DAT_HI;
            rx_ready  <= 1'b1;
          end
        end
`ifdef BOOT_CHECKSUM_EN
        CHK_HI: begin
          if (rx_accept) begin
            hi_reg    <= rx_data;
            state_reg <= CHK_LO;
          end
        end
        CHK_LO: begin
          if (rx_accept) begin
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            if ({hi_reg, rx_data} == sum_reg) begin
              state_reg <= DONE;
              cpu_run   <= 1'b1;
            end else begin
              state_reg <= ERR;
              error     <= 1'b1;
            end
          end
        end
`endif
        DONE: begin
          state_reg <= DONE;
        end
        ERR: begin
          state_reg <= ERR;
        end
        default: begin
          // Unreachable encodings are treated as a failed load.
          state_reg <= ERR;
          rx_ready  <= 1'b0;
          imem_we   <= 1'b0;
          cpu_run   <= 1'b0;
          busy      <= 1'b0;
          error     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: randomized scoreboard bench for boot_loader.
// Stimulus builds byte images. A reference model derives the expected
// memory writes and the final outcome from the image format. A monitor
// pops and compares each write as the DUT presents it.
module tb_boot_loader;

  localparam logic [15:0] BASE = 16'h0000;
  localparam int          MAXW = 256;
  localparam int          CW   = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          imem_we;
  logic [15:0]   imem_addr;
  logic [15:0]   imem_wdata;
  logic          cpu_run;
  logic          busy;
  logic          error;
  logic [CW-1:0] word_count;

  always #5 clock = ~clock;

  boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .CNT_W(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .busy       (busy),
    .error      (error),
    .word_count (word_count)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic        last;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] img_q[$];
  int         checks = 0;
  int         passes = 0;
  bit         pending_run = 0;
  wr_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clock) begin
    if (pending_run) begin
      check("cpu_run_after_last_write", {31'b0, cpu_run}, 32'd1);
      pending_run = 0;
    end
    if (reset && imem_we) begin
      $display("write addr=0x%04h data=0x%04h", imem_addr, imem_wdata);
      check("we_ready_exclusive", {31'b0, rx_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        check("spurious_write", exp_q.size(), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", {16'b0, imem_addr}, {16'b0, mon_e.addr});
        check("write_data", {16'b0, imem_wdata}, {16'b0, mon_e.data});
        if (mon_e.last) pending_run = 1;
      end
    end
  end

  task automatic check_reset_values();
    check("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
    check("rst_imem_we", {31'b0, imem_we}, 32'd0);
    check("rst_imem_addr", {16'b0, imem_addr}, {16'b0, BASE});
    check("rst_imem_wdata", {16'b0, imem_wdata}, 32'd0);
    check("rst_cpu_run", {31'b0, cpu_run}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd1);
    check("rst_error", {31'b0, error}, 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rx_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check_reset_values();
    reset = 1'b1;
  endtask

  // Offer one byte after 'gap' idle cycles; hold it until rx_ready is seen,
  // so the following rising edge accepts it.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      @(negedge clock);
      rx_valid = 1'b0;
    end
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data = b;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("rx_ready_timeout", n, 32'd0);
  endtask

  // Reference model + driver for the image held in img_q.
  task automatic run_image(input string tag, input int maxgap);
    int          len;
    int          nsend;
    int          exp_cnt;
    int          n;
    bit          exp_err;
    logic [15:0] sum;
    logic [15:0] got;
    wr_t         e;
    len = {img_q[0], img_q[1]};
    exp_err = 0;
    sum = 16'h0000;
    if (len > MAXW) begin
      exp_err = 1;
      nsend = 2;
      exp_cnt = 0;
    end else begin
      for (int i = 0; i < len; i++) begin
        e.addr = BASE + 16'(2 * i);
        e.data = {img_q[2 + 2 * i], img_q[3 + 2 * i]};
`ifdef BOOT_CHECKSUM_EN
        e.last = 1'b0;
`else
        e.last = (i == len - 1);
`endif
        sum = sum + e.data;
        exp_q.push_back(e);
      end
      nsend = 2 + 2 * len;
      exp_cnt = len;
`ifdef BOOT_CHECKSUM_EN
      got = {img_q[nsend], img_q[nsend + 1]};
      nsend = nsend + 2;
      exp_err = (got != sum);
`else
      got = sum;
`endif
    end
    $display("image %s len=%0d bytes=%0d expect_err=%0d", tag, len, nsend, exp_err);
    for (int i = 0; i < nsend; i++) send_byte(img_q[i], int'($urandom_range(0, maxgap)));
    @(negedge clock);
    rx_valid = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check("done_timeout", n, 32'd0);
    check("end_cpu_run", {31'b0, cpu_run}, {31'b0, !exp_err});
    check("end_error", {31'b0, error}, {31'b0, exp_err});
    check("end_busy", {31'b0, busy}, 32'd0);
    check("end_rx_ready", {31'b0, rx_ready}, 32'd0);
    check("end_word_count", 32'(word_count), exp_cnt);
    check("end_pending_writes", exp_q.size(), 32'd0);
    // Terminal state must refuse further bytes and write nothing.
    rx_valid = 1'b1;
    rx_data = 8'h5A;
    repeat (3) begin
      @(negedge clock);
      check("terminal_rx_ready", {31'b0, rx_ready}, 32'd0);
    end
    rx_valid = 1'b0;
    check("terminal_word_count", 32'(word_count), exp_cnt);
  endtask

  task automatic build_random(input int len, input bit bad_chk);
    logic [15:0] w;
    logic [15:0] s;
    img_q.delete();
    img_q.push_back(8'(len >> 8));
    img_q.push_back(8'(len));
    s = 16'h0000;
    for (int i = 0; i < len; i++) begin
      w = 16'($urandom);
      s = s + w;
      img_q.push_back(w[15:8]);
      img_q.push_back(w[7:0]);
    end
`ifdef BOOT_CHECKSUM_EN
    if (bad_chk) s = s ^ 16'h0001;
    img_q.push_back(s[15:8]);
    img_q.push_back(s[7:0]);
`else
    if (bad_chk) s = 16'h0000;
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int          len;
    repeat (2) @(negedge clock);
    check_reset_values();
    reset = 1'b1;

    // Two-word image, back to back.
    img_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef BOOT_CHECKSUM_EN
    img_q.push_back(8'hBE);
    img_q.push_back(8'h01);
`endif
    run_image("two_words_b2b", 0);
    do_reset();

    // Same image with random idle gaps.
    run_image("two_words_gaps", 5);
    do_reset();

    // Empty image.
    img_q = '{8'h00, 8'h00};
`ifdef BOOT_CHECKSUM_EN
    img_q.push_back(8'h00);
    img_q.push_back(8'h00);
`endif
    run_image("empty", 0);
    do_reset();

    // One past the maximum length.
    img_q = '{8'h01, 8'h01};
    run_image("len_257", 2);
    do_reset();

`ifdef BOOT_CHECKSUM_EN
    img_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h02};
    run_image("bad_checksum", 1);
    do_reset();
`endif

    // Exactly the maximum length.
    build_random(MAXW, 1'b0);
    run_image("len_max", 0);
    do_reset();

    // Random images with random gaps, plus random oversized headers.
    for (int t = 0; t < 6; t++) begin
      build_random(int'($urandom_range(1, 8)), ($urandom_range(0, 3) == 0));
      run_image("random", 5);
      do_reset();
    end
    for (int t = 0; t < 2; t++) begin
      len = int'($urandom_range(MAXW + 1, 65535));
      img_q = '{8'(len >> 8), 8'(len)};
      run_image("random_oversize", 3);
      do_reset();
    end

    // Reset while word 3 of 5 is waiting for its low byte.
    build_random(5, 1'b0);
    for (int i = 0; i < 2; i++) begin
      mon_e.addr = BASE + 16'(2 * i);
      mon_e.data = {img_q[2 + 2 * i], img_q[3 + 2 * i]};
      mon_e.last = 1'b0;
      exp_q.push_back(mon_e);
    end
    $display("image abort len=5 bytes=7");
    for (int i = 0; i < 7; i++) send_byte(img_q[i], int'($urandom_range(0, 2)));
    @(negedge clock);
    rx_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check_reset_values();
    check("abort_pending_writes", exp_q.size(), 32'd0);
    reset = 1'b1;
    w = 16'($urandom);
    img_q = '{8'h00, 8'h01, w[15:8], w[7:0]};
`ifdef BOOT_CHECKSUM_EN
    img_q.push_back(w[15:8]);
    img_q.push_back(w[7:0]);
`endif
    run_image("after_abort", 2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
